// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instructions (ADD/SUB/AND/OR/NOR,
// ADDI, ORI, LUI) into 32-bit machine words. Each word is written into
// instruction memory at an auto-incrementing word address.
// Two-state FSM (IDLE -> WRITE): one instruction every two cycles.
// Optional build macro: INSTR_ENC_CHECK_EN. When it is defined, illegal
// op codes are accepted but not written, and they set a sticky err_o.
// When it is undefined, illegal op codes are written as a NOP and err_o
// is tied low.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            op_sel_i,
  input  logic [4:0]            rs_i,
  input  logic [4:0]            rt_i,
  input  logic [4:0]            rd_i,
  input  logic [15:0]           imm_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full;
  logic [31:0]           enc_word;
  logic                  wr_ok;
  logic                  accept;

  // Write pointer is the low bits of the count; a full count never wraps it.
  assign full   = (count_q == FULL_CNT);
  assign accept = (state_q == IDLE) && valid_i && !full && !start_i;

  // Opcode/funct encoder; illegal codes fall through to NOP.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (op_sel_i)
      4'd0: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, 6'h20};
      4'd1: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, 6'h22};
      4'd2: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, 6'h24};
      4'd3: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, 6'h25};
      4'd4: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, 6'h27};
      4'd5: enc_word = {6'h08, rs_i, rt_i, imm_i};
      4'd6: enc_word = {6'h0D, rs_i, rt_i, imm_i};
      4'd7: enc_word = {6'h0F, 5'b0, rt_i, imm_i};
      default: enc_word = 32'h0000_0000;
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  logic err_q;

  // Only op codes 0..7 are real instructions; op_sel_i[3] marks 8..15.
  assign wr_ok = !op_sel_i[3];
  assign err_o = err_q;

  // Sticky error flag: set by an accepted illegal op, cleared by start/reset.
  always_ff @(posedge clk) begin
    if (reset)                           err_q <= 1'b0;
    else if (start_i && !accept)         err_q <= 1'b0;
    else if (accept && op_sel_i[3])      err_q <= 1'b1;
  end
`else
  assign wr_ok = 1'b1;
  assign err_o = 1'b0;
`endif

  // Handshake FSM with registered memory-write outputs and word count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            count_q <= '0;
          end else if (accept) begin
            mem_addr_q  <= count_q[ADDR_WIDTH-1:0];
            mem_wdata_q <= wr_ok ? enc_word : 32'h0000_0000;
            mem_we_q    <= wr_ok;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          // The write strobe was raised on accept; it lasts one cycle.
          // A start during this cycle lets the write land but discards
          // the count.
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
          if (start_i)       count_q <= '0;
          else if (mem_we_q) count_q <= count_q + ONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE) && !full;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign count_o     = count_q;
  assign full_o      = full;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with ADDR_WIDTH=2 (4-word memory).
// Exercises encodings, fill-to-full, start in IDLE/WRITE, illegal ops
// (both build variants) and reset mid-WRITE.
module tb_instr_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, start_i, valid_i;
  logic          ready_o;
  logic [3:0]    op_sel_i;
  logic [4:0]    rs_i, rt_i, rd_i;
  logic [15:0]   imm_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o, err_o;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .valid_i(valid_i),
    .ready_o(ready_o), .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .imm_i(imm_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .count_o(count_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present an instruction, clock the accept edge, then check the write beat.
  task automatic send(input string tag, input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    op_sel_i = op; rs_i = rs; rt_i = rt; rd_i = rd; imm_i = imm; valid_i = 1'b1;
    chk({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    chk({tag, "_ready_wr"}, {31'b0, ready_o}, 32'd0);
    chk({tag, "_we"}, {31'b0, mem_we_o}, {31'b0, we});
    if (we) begin
      chk({tag, "_addr"}, {30'b0, mem_addr_o}, addr);
      chk({tag, "_wdata"}, mem_wdata_o, wdata);
    end
  endtask

  task automatic post(input string tag, input logic [31:0] cnt, input logic full, input logic err);
    tick();
    chk({tag, "_we_off"}, {31'b0, mem_we_o}, 32'd0);
    chk({tag, "_count"}, {29'b0, count_o}, cnt);
    chk({tag, "_full"}, {31'b0, full_o}, {31'b0, full});
    chk({tag, "_err"}, {31'b0, err_o}, {31'b0, err});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_i = 1'b0; valid_i = 1'b0;
    op_sel_i = 4'd0; rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0; imm_i = 16'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_addr", {30'b0, mem_addr_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_count", {29'b0, count_o}, 32'd0);
    chk("rst_full", {31'b0, full_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);

    // Fill all four words.
    send("addi", 4'd5, 5'd0, 5'd8, 5'd0, 16'h0005, 1'b1, 32'd0, 32'h2008_0005);
    post("addi", 32'd1, 1'b0, 1'b0);
    send("add", 4'd0, 5'd8, 5'd9, 5'd10, 16'hFFFF, 1'b1, 32'd1, 32'h0109_5020);
    post("add", 32'd2, 1'b0, 1'b0);
    send("lui", 4'd7, 5'd7, 5'd1, 5'd3, 16'h1001, 1'b1, 32'd2, 32'h3C01_1001);
    post("lui", 32'd3, 1'b0, 1'b0);
    send("ori", 4'd6, 5'd1, 5'd1, 5'd0, 16'h0024, 1'b1, 32'd3, 32'h3421_0024);
    post("ori", 32'd4, 1'b1, 1'b0);

    // Full: valid held high, nothing accepted.
    valid_i = 1'b1; op_sel_i = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_ready", {31'b0, ready_o}, 32'd0);
      chk("full_we", {31'b0, mem_we_o}, 32'd0);
      chk("full_count", {29'b0, count_o}, 32'd4);
    end

    // Start with valid high: clears, no accept.
    start_i = 1'b1;
    tick();
    start_i = 1'b0; valid_i = 1'b0;
    chk("start_we", {31'b0, mem_we_o}, 32'd0);
    chk("start_count", {29'b0, count_o}, 32'd0);
    chk("start_full", {31'b0, full_o}, 32'd0);
    chk("start_ready", {31'b0, ready_o}, 32'd1);

    // A start while ready: still no accept.
    start_i = 1'b1; valid_i = 1'b1; op_sel_i = 4'd5;
    tick();
    start_i = 1'b0; valid_i = 1'b0;
    chk("start_idle_we", {31'b0, mem_we_o}, 32'd0);
    chk("start_idle_ready", {31'b0, ready_o}, 32'd1);
    chk("start_idle_count", {29'b0, count_o}, 32'd0);

    send("sub", 4'd1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b1, 32'd0, 32'h0022_1822);
    post("sub", 32'd1, 1'b0, 1'b0);
    send("and", 4'd2, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b1, 32'd1, 32'h0085_3024);
    post("and", 32'd2, 1'b0, 1'b0);

`ifdef INSTR_ENC_CHECK_EN
    send("ill", 4'd9, 5'd1, 5'd2, 5'd3, 16'h5555, 1'b0, 32'd0, 32'd0);
    chk("ill_err_early", {31'b0, err_o}, 32'd1);
    post("ill", 32'd2, 1'b0, 1'b1);
    // Start during WRITE: write completes, counters and err clear.
    send("nor", 4'd4, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 32'd2, 32'h0000_0027);
`else
    send("ill", 4'd9, 5'd1, 5'd2, 5'd3, 16'h5555, 1'b1, 32'd2, 32'h0000_0000);
    post("ill", 32'd3, 1'b0, 1'b0);
    send("nor", 4'd4, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 32'd3, 32'h0000_0027);
`endif
    start_i = 1'b1;
    post("start_wr", 32'd0, 1'b0, 1'b0);
    start_i = 1'b0;
    send("after_start", 4'd5, 5'd2, 5'd3, 5'd0, 16'hFFFE, 1'b1, 32'd0, 32'h2043_FFFE);
    post("after_start", 32'd1, 1'b0, 1'b0);

    // Reset during WRITE.
    send("or", 4'd3, 5'd31, 5'd31, 5'd31, 16'h0000, 1'b1, 32'd1, 32'h03FF_F825);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_we", {31'b0, mem_we_o}, 32'd0);
    chk("rmid_addr", {30'b0, mem_addr_o}, 32'd0);
    chk("rmid_wdata", mem_wdata_o, 32'd0);
    chk("rmid_count", {29'b0, count_o}, 32'd0);
    chk("rmid_ready", {31'b0, ready_o}, 32'd1);
    chk("rmid_err", {31'b0, err_o}, 32'd0);
    tick();
    chk("rmid_we2", {31'b0, mem_we_o}, 32'd0);
    chk("rmid_count2", {29'b0, count_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
